mux_scan_sampler: RTL and testbench

- Upstream/downstream companion to the 4-to-1 single-bit selector. Drives the selector's 2-bit select and samples its 1-bit output.
- Walks select 0..3, waits a programmable settle time on each channel, and assembles the four samples into a 4-bit word.
- Delivers the word to the consumer over a valid/ready handshake.
- Used to serialise four slow status lines through one shared mux path.

---
 rtl/mux_scan_sampler.sv | 127 ++++++++++++
 tb/tb_mux_scan_sampler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sampler.sv
// mux_scan_sampler: drives a 4:1 single-bit mux select through channels 0..3,
// holds each channel for SETTLE_CYCLES cycles, samples the mux output at the
// end of each hold and delivers the assembled 4-bit word over valid/ready.
module mux_scan_sampler #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter bit          CONTINUOUS    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [1:0] mux_sel,
    input  logic       mux_bit,
    output logic [3:0] word,
    output logic       word_valid,
    input  logic       word_ready,
    output logic       busy,
    output logic       overrun,
    input  logic       clr_overrun
);

    localparam int unsigned   CW     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        SETTLE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_sel;
    logic [1:0]    w_sel_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [3:0]    r_shift;
    logic [3:0]    w_shift_nxt;
    logic          w_done;
    logic          w_drop;
    logic          w_load;
    logic [3:0]    r_word;
    logic          r_valid;
    logic          r_overrun;

    // Scan state, select, settle counter and sample shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next-state logic: settle countdown, per-channel capture, word completion.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                w_sel_nxt = '0;
                if (start || CONTINUOUS) begin
                    w_state_nxt = SETTLE;
                    w_cnt_nxt   = RELOAD;
                end
            end
            SETTLE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_shift_nxt[r_sel] = mux_bit;
                    w_cnt_nxt          = RELOAD;
                    if (r_sel != 2'd3) begin
                        w_sel_nxt = r_sel + 2'd1;
                    end else begin
                        w_done      = 1'b1;
                        w_sel_nxt   = '0;
                        w_state_nxt = CONTINUOUS ? SETTLE : IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_sel_nxt   = '0;
            end
        endcase
    end

    // A completed word is dropped only if the held word is not leaving this cycle.
    assign w_drop = w_done && r_valid && !word_ready;
    assign w_load = w_done && !w_drop;

    // Output word register, valid/ready handshake and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_word  <= w_shift_nxt;
                r_valid <= 1'b1;
            end else if (r_valid && word_ready) begin
                r_valid <= 1'b0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign mux_sel    = r_sel;
    assign word       = r_word;
    assign word_valid = r_valid;
    assign busy       = (r_state == SETTLE);
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Bench for mux_scan_sampler: three instances (one-shot S=2, continuous S=2,
// one-shot S=1) each driven through a behavioural 4:1 mux. Expected words go
// into per-instance queues; monitors pop and compare on every handshake.
module tb_mux_scan_sampler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: SETTLE_CYCLES=2, one-shot
    logic       rst_a = 1'b1, start_a = 1'b0, ready_a = 1'b0, clr_a = 1'b0;
    logic [3:0] d_a = '0;
    logic [1:0] sel_a;
    logic [3:0] word_a;
    logic       valid_a, busy_a, ovr_a, bit_a;
    assign bit_a = d_a[sel_a];

    // Instance B: SETTLE_CYCLES=2, continuous
    logic       rst_b = 1'b1, start_b = 1'b0, ready_b = 1'b0, clr_b = 1'b0;
    logic [3:0] d_b = '0;
    logic [1:0] sel_b;
    logic [3:0] word_b;
    logic       valid_b, busy_b, ovr_b, bit_b;
    assign bit_b = d_b[sel_b];

    // Instance C: SETTLE_CYCLES=1, one-shot
    logic       rst_c = 1'b1, start_c = 1'b0, ready_c = 1'b0, clr_c = 1'b0;
    logic [3:0] d_c = '0;
    logic [1:0] sel_c;
    logic [3:0] word_c;
    logic       valid_c, busy_c, ovr_c, bit_c;
    assign bit_c = d_c[sel_c];

    mux_scan_sampler #(.SETTLE_CYCLES(2), .CONTINUOUS(1'b0)) u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .mux_sel(sel_a), .mux_bit(bit_a),
        .word(word_a), .word_valid(valid_a), .word_ready(ready_a), .busy(busy_a),
        .overrun(ovr_a), .clr_overrun(clr_a)
    );

    mux_scan_sampler #(.SETTLE_CYCLES(2), .CONTINUOUS(1'b1)) u_b (
        .clk(clk), .rst(rst_b), .start(start_b), .mux_sel(sel_b), .mux_bit(bit_b),
        .word(word_b), .word_valid(valid_b), .word_ready(ready_b), .busy(busy_b),
        .overrun(ovr_b), .clr_overrun(clr_b)
    );

    mux_scan_sampler #(.SETTLE_CYCLES(1), .CONTINUOUS(1'b0)) u_c (
        .clk(clk), .rst(rst_c), .start(start_c), .mux_sel(sel_c), .mux_bit(bit_c),
        .word(word_c), .word_valid(valid_c), .word_ready(ready_c), .busy(busy_c),
        .overrun(ovr_c), .clr_overrun(clr_c)
    );

    logic [3:0] exp_a[$];
    logic [3:0] exp_b[$];
    logic [3:0] exp_c[$];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: every accepted word must match the next queued one.
    always @(negedge clk) begin
        if (!rst_a && valid_a && ready_a) begin
            total++;
            if (exp_a.size() == 0) begin
                bad++;
                $display("FAIL mon_a_unexpected: got %b want none", word_a);
            end else begin
                logic [3:0] e;
                e = exp_a.pop_front();
                if (word_a !== e) begin
                    bad++;
                    $display("FAIL mon_a_word: got %b want %b", word_a, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b && valid_b && ready_b) begin
            total++;
            if (exp_b.size() == 0) begin
                bad++;
                $display("FAIL mon_b_unexpected: got %b want none", word_b);
            end else begin
                logic [3:0] e;
                e = exp_b.pop_front();
                if (word_b !== e) begin
                    bad++;
                    $display("FAIL mon_b_word: got %b want %b", word_b, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_c && valid_c && ready_c) begin
            total++;
            if (exp_c.size() == 0) begin
                bad++;
                $display("FAIL mon_c_unexpected: got %b want none", word_c);
            end else begin
                logic [3:0] e;
                e = exp_c.pop_front();
                if (word_c !== e) begin
                    bad++;
                    $display("FAIL mon_c_word: got %b want %b", word_c, e);
                end
            end
        end
    end

    initial begin
        // ---- Reset and one-shot capture (A) ----
        cyc(2);
        check("a_rst_sel", {2'b00, sel_a}, 4'd0);
        check("a_rst_busy", {3'b0, busy_a}, 4'd0);
        check("a_rst_valid", {3'b0, valid_a}, 4'd0);
        check("a_rst_word", word_a, 4'd0);
        check("a_rst_ovr", {3'b0, ovr_a}, 4'd0);
        rst_a = 1'b0; d_a = 4'b1010; ready_a = 1'b1; start_a = 1'b1;
        exp_a.push_back(4'b1010);
        cyc(1);                      // edge 0 sampled start; now cycle 1
        start_a = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) cyc(1);
            check($sformatf("a_sel_c%0d", k), {2'b00, sel_a}, 4'((k - 1) / 2));
            check($sformatf("a_busy_c%0d", k), {3'b0, busy_a}, 4'd1);
            check($sformatf("a_valid_c%0d", k), {3'b0, valid_a}, 4'd0);
        end
        cyc(1);                      // cycle 9
        check("a_c9_valid", {3'b0, valid_a}, 4'd1);
        check("a_c9_word", word_a, 4'b1010);
        check("a_c9_busy", {3'b0, busy_a}, 4'd0);
        cyc(1);                      // cycle 10
        check("a_c10_valid", {3'b0, valid_a}, 4'd0);
        check("a_c10_busy", {3'b0, busy_a}, 4'd0);

        // ---- Inactive-channel data changes (A) ----
        d_a = 4'b0101; start_a = 1'b1;
        exp_a.push_back(4'b0101);
        cyc(1); start_a = 1'b0; d_a[3] = 1'b1;   // cycle 1, sel 0
        cyc(1); d_a[3] = 1'b0;                   // cycle 2, sel 0
        cyc(1); d_a[3] = 1'b1;                   // cycle 3, sel 1
        cyc(2); d_a[3] = 1'b0;                   // cycle 5, sel 2
        cyc(4);                                  // cycle 9
        check("a_inact_valid", {3'b0, valid_a}, 4'd1);
        check("a_inact_word", word_a, 4'b0101);
        cyc(1);

        // ---- Reset mid-scan (A) ----
        d_a = 4'b1111; start_a = 1'b1;
        cyc(1); start_a = 1'b0;                  // cycle 1
        cyc(4);                                  // cycle 5
        check("a_mid_sel2", {2'b00, sel_a}, 4'd2);
        rst_a = 1'b1;
        cyc(1);
        check("a_mid_sel", {2'b00, sel_a}, 4'd0);
        check("a_mid_busy", {3'b0, busy_a}, 4'd0);
        check("a_mid_valid", {3'b0, valid_a}, 4'd0);
        check("a_mid_word", word_a, 4'd0);
        rst_a = 1'b0; d_a = 4'b0100; start_a = 1'b1;
        exp_a.push_back(4'b0100);
        cyc(1); start_a = 1'b0;
        cyc(8);
        check("a_fresh_valid", {3'b0, valid_a}, 4'd1);
        check("a_fresh_word", word_a, 4'b0100);
        cyc(1);

        // ---- Start ignored while busy (C, SETTLE_CYCLES=1) ----
        rst_c = 1'b0; d_c = 4'b1001; ready_c = 1'b1; start_c = 1'b1;
        exp_c.push_back(4'b1001);
        cyc(1); start_c = 1'b0;                  // cycle 1
        cyc(1); start_c = 1'b1;                  // cycle 2
        cyc(1); start_c = 1'b0;                  // cycle 3
        check("c_c3_sel", {2'b00, sel_c}, 4'd2);
        check("c_c3_busy", {3'b0, busy_c}, 4'd1);
        cyc(1);                                  // cycle 4
        check("c_c4_sel", {2'b00, sel_c}, 4'd3);
        check("c_c4_valid", {3'b0, valid_c}, 4'd0);
        cyc(1);                                  // cycle 5
        check("c_c5_valid", {3'b0, valid_c}, 4'd1);
        check("c_c5_word", word_c, 4'b1001);
        check("c_c5_busy", {3'b0, busy_c}, 4'd0);
        for (int k = 6; k <= 12; k++) begin
            cyc(1);
            check($sformatf("c_idle_busy_c%0d", k), {3'b0, busy_c}, 4'd0);
            check($sformatf("c_idle_valid_c%0d", k), {3'b0, valid_c}, 4'd0);
        end

        // ---- Backpressure and overrun (B, continuous) ----
        d_b = 4'b0110; ready_b = 1'b0;
        exp_b.push_back(4'b0110);
        rst_b = 1'b0;                            // E0 was the last reset edge
        cyc(9);                                  // after first completion
        check("b_w1_valid", {3'b0, valid_b}, 4'd1);
        check("b_w1_word", word_b, 4'b0110);
        check("b_w1_ovr", {3'b0, ovr_b}, 4'd0);
        d_b = 4'b1111;
        cyc(8);                                  // after second completion
        check("b_w2_ovr", {3'b0, ovr_b}, 4'd1);
        check("b_w2_word", word_b, 4'b0110);
        check("b_w2_valid", {3'b0, valid_b}, 4'd1);
        ready_b = 1'b1; clr_b = 1'b1;
        exp_b.push_back(4'b1111);
        cyc(1);
        clr_b = 1'b0;
        check("b_clr_ovr", {3'b0, ovr_b}, 4'd0);
        check("b_clr_valid", {3'b0, valid_b}, 4'd0);
        cyc(7);                                  // after third completion
        check("b_w3_valid", {3'b0, valid_b}, 4'd1);
        check("b_w3_word", word_b, 4'b1111);
        check("b_w3_ovr", {3'b0, ovr_b}, 4'd0);
        cyc(1);
        ready_b = 1'b0;
        check("b_w3_taken", {3'b0, valid_b}, 4'd0);

        // ---- Simultaneous accept and complete (B) ----
        rst_b = 1'b1; d_b = 4'b0011;
        exp_b.push_back(4'b0011);
        cyc(2);
        check("b_rst_valid", {3'b0, valid_b}, 4'd0);
        check("b_rst_ovr", {3'b0, ovr_b}, 4'd0);
        rst_b = 1'b0;
        cyc(9);                                  // scan 1 done
        check("b_s1_word", word_b, 4'b0011);
        check("b_s1_valid", {3'b0, valid_b}, 4'd1);
        d_b = 4'b1100;
        cyc(7);                                  // completion cycle of scan 2
        check("b_s2pre_word", word_b, 4'b0011);
        check("b_s2pre_ovr", {3'b0, ovr_b}, 4'd0);
        ready_b = 1'b1;
        cyc(1);
        ready_b = 1'b0;
        check("b_s2_word", word_b, 4'b1100);
        check("b_s2_valid", {3'b0, valid_b}, 4'd1);
        check("b_s2_ovr", {3'b0, ovr_b}, 4'd0);
        rst_b = 1'b1;
        cyc(2);

        check("a_queue_left", 4'(exp_a.size()), 4'd0);
        check("b_queue_left", 4'(exp_b.size()), 4'd0);
        check("c_queue_left", 4'(exp_c.size()), 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
